// File: rtl/instruction_fetch.sv
// IF stage + IF/ID register: PC owner, sync imem addressing, one-entry skid across stalls, branch redirect.
// Latency 2 cycles pc->IF/ID; stall holds everything; optional macro BRANCH_DELAY_SLOT_EN keeps the in-flight slot on redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_INCREMENT = 32'd4,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [31:0] imemAddress,
  input  logic [31:0] imemReadData,
  output logic [31:0] instruction,
  output logic [31:0] programCounterOut,
  output logic        instructionValid
);

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_inflight_vld, w_inflight_vld_nxt;
  logic [31:0] r_inflight_pc, w_inflight_pc_nxt;
  logic        r_skid_vld, w_skid_vld_nxt;
  logic [31:0] r_skid_word, w_skid_word_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc_out, w_pc_out_nxt;
  logic        r_instr_vld, w_instr_vld_nxt;

  // Skid is only ever valid in HOLD, where the in-flight slot has been retired into it.
  logic        w_src_vld;
  logic [31:0] w_src_word, w_src_pc;
  assign w_src_vld  = r_skid_vld | r_inflight_vld;
  assign w_src_word = r_skid_vld ? r_skid_word : imemReadData;
  assign w_src_pc   = r_skid_vld ? r_skid_pc : r_inflight_pc;

  assign imemAddress       = r_pc;
  assign instruction       = r_instr;
  assign programCounterOut = r_pc_out;
  assign instructionValid  = r_instr_vld;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (branchTaken) begin
`ifdef BRANCH_DELAY_SLOT_EN
      w_state_nxt = (stall && w_src_vld) ? HOLD : FILL;
`else
      w_state_nxt = FILL;
`endif
    end else if (stall) begin
      if (r_state == RUN && r_inflight_vld) w_state_nxt = HOLD;
    end else begin
      w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_pc_nxt           = r_pc;
    w_inflight_vld_nxt = r_inflight_vld;
    w_inflight_pc_nxt  = r_inflight_pc;
    w_skid_vld_nxt     = r_skid_vld;
    w_skid_word_nxt    = r_skid_word;
    w_skid_pc_nxt      = r_skid_pc;
    w_instr_nxt        = r_instr;
    w_pc_out_nxt       = r_pc_out;
    w_instr_vld_nxt    = r_instr_vld;
    if (branchTaken) begin
      w_pc_nxt           = branchTarget;
      w_inflight_vld_nxt = 1'b0;
      w_skid_vld_nxt     = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      if (stall) begin
        w_skid_vld_nxt  = w_src_vld;
        w_skid_word_nxt = w_src_word;
        w_skid_pc_nxt   = w_src_pc;
      end else begin
        w_instr_nxt     = w_src_vld ? w_src_word : NOP_WORD;
        w_pc_out_nxt    = w_src_vld ? w_src_pc + PC_INCREMENT : r_pc_out;
        w_instr_vld_nxt = w_src_vld;
      end
`else
      w_instr_nxt     = NOP_WORD;
      w_instr_vld_nxt = 1'b0;
`endif
    end else if (stall) begin
      // The returning read would be lost while IF/ID is frozen; park it.
      if (r_state == RUN && r_inflight_vld) begin
        w_skid_vld_nxt     = 1'b1;
        w_skid_word_nxt    = imemReadData;
        w_skid_pc_nxt      = r_inflight_pc;
        w_inflight_vld_nxt = 1'b0;
      end
    end else begin
      if (r_state != FILL) begin
        w_instr_nxt     = w_src_vld ? w_src_word : NOP_WORD;
        w_pc_out_nxt    = w_src_vld ? w_src_pc + PC_INCREMENT : r_pc_out;
        w_instr_vld_nxt = w_src_vld;
      end
      w_skid_vld_nxt     = 1'b0;
      w_inflight_vld_nxt = 1'b1;
      w_inflight_pc_nxt  = r_pc;
      w_pc_nxt           = r_pc + PC_INCREMENT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_VECTOR;
      r_inflight_vld <= 1'b0;
      r_inflight_pc  <= 32'h0;
      r_skid_vld     <= 1'b0;
      r_skid_word    <= 32'h0;
      r_skid_pc      <= 32'h0;
      r_instr        <= NOP_WORD;
      r_pc_out       <= 32'h0;
      r_instr_vld    <= 1'b0;
    end else begin
      r_pc           <= w_pc_nxt;
      r_inflight_vld <= w_inflight_vld_nxt;
      r_inflight_pc  <= w_inflight_pc_nxt;
      r_skid_vld     <= w_skid_vld_nxt;
      r_skid_word    <= w_skid_word_nxt;
      r_skid_pc      <= w_skid_pc_nxt;
      r_instr        <= w_instr_nxt;
      r_pc_out       <= w_pc_out_nxt;
      r_instr_vld    <= w_instr_vld_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: imem returns word == address; second instance checks a wrapping RESET_VECTOR.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, br;
  logic [31:0] tgt;
  logic [31:0] imem_adr, imem_dat, ins, pco;
  logic        vld;
  logic        rv_stall, rv_br;
  logic [31:0] rv_tgt, rv_adr, rv_dat, rv_ins, rv_pco;
  logic        rv_vld;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_dat <= imem_adr;
    rv_dat   <= rv_adr;
  end

  instruction_fetch u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(br), .branchTarget(tgt),
    .imemAddress(imem_adr), .imemReadData(imem_dat),
    .instruction(ins), .programCounterOut(pco), .instructionValid(vld)
  );

  instruction_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_rv (
    .clk(clk), .reset(reset), .stall(rv_stall), .branchTaken(rv_br), .branchTarget(rv_tgt),
    .imemAddress(rv_adr), .imemReadData(rv_dat),
    .instruction(rv_ins), .programCounterOut(rv_pco), .instructionValid(rv_vld)
  );

  typedef struct {
    logic        rst, stl, brt;
    logic [31:0] tgt;
    logic [31:0] e_ins, e_pco;
    logic        e_vld;
    logic [31:0] e_adr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
  endtask

  task automatic tick(input logic r, input logic s, input logic b, input logic [31:0] t);
    reset = r; stall = s; br = b; tgt = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    rv_stall = 1'b0; rv_br = 1'b0; rv_tgt = 32'h0;

    //                rst stl br  tgt      ins       pco       vld  adr
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    1'b0, 32'h4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h4,    1'b1, 32'h8});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h4,    32'h8,    1'b1, 32'hC});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,    32'hC,    1'b1, 32'h10});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h8,    32'hC,    1'b1, 32'h10});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h8,    32'hC,    1'b1, 32'h10});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h8,    32'hC,    1'b1, 32'h10});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'hC,    32'h10,   1'b1, 32'h14});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h10,   32'h14,   1'b1, 32'h18});
`ifdef BRANCH_DELAY_SLOT_EN
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h100, 32'h14,   32'h18,   1'b1, 32'h100});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h14,   32'h18,   1'b1, 32'h104});
`else
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h100, 32'h0,    32'h14,   1'b0, 32'h100});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h14,   1'b0, 32'h104});
`endif
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h100,  32'h104,  1'b1, 32'h108});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h104,  32'h108,  1'b1, 32'h10C});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h104,  32'h108,  1'b1, 32'h10C});
`ifdef BRANCH_DELAY_SLOT_EN
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h200, 32'h104,  32'h108,  1'b1, 32'h200});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h104,  32'h108,  1'b1, 32'h200});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h108,  32'h10C,  1'b1, 32'h204});
`else
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h200, 32'h0,    32'h108,  1'b0, 32'h200});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h0,    32'h108,  1'b0, 32'h200});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h108,  1'b0, 32'h204});
`endif
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h200,  32'h204,  1'b1, 32'h208});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h204,  32'h208,  1'b1, 32'h20C});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   32'h204,  32'h208,  1'b1, 32'h20C});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,    1'b0, 32'h4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h4,    1'b1, 32'h8});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].stl, tbl[i].brt, tbl[i].tgt);
      chk("instruction", i, ins, tbl[i].e_ins);
      chk("programCounterOut", i, pco, tbl[i].e_pco);
      chk("instructionValid", i, {31'h0, vld}, {31'h0, tbl[i].e_vld});
      chk("imemAddress", i, imem_adr, tbl[i].e_adr);
    end

    // Reset vector at the top of the address space: PC wraps to 0.
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rv_reset_addr", 100, rv_adr, 32'hFFFF_FFFC);
    chk("rv_reset_vld", 100, {31'h0, rv_vld}, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rv_wrap_addr", 101, rv_adr, 32'h0);
    chk("rv_fill_vld", 101, {31'h0, rv_vld}, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rv_first_ins", 102, rv_ins, 32'hFFFF_FFFC);
    chk("rv_first_pco", 102, rv_pco, 32'h0);
    chk("rv_first_vld", 102, {31'h0, rv_vld}, 32'h1);
    chk("rv_next_addr", 102, rv_adr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
